// File: rtl/opensocdebug_pkg.sv
// Shared debug-trace definitions: event record, kind/flag constants, filter modes
// and the saturating drop-count helper.
package opensocdebug;

  localparam int CTM_ADDR_W = 32;
  localparam int CTM_TIME_W = 32;

  localparam logic CTM_KIND_INSTR    = 1'b0;
  localparam logic CTM_KIND_OVERFLOW = 1'b1;

  localparam int CTM_FLAG_JAL  = 0;
  localparam int CTM_FLAG_JALR = 1;
  localparam int CTM_FLAG_BR   = 2;
  localparam int CTM_FLAG_XCPT = 3;

  typedef enum logic [1:0] {
    CTM_MODE_ALL  = 2'd0,
    CTM_MODE_CTRL = 2'd1,
    CTM_MODE_XCPT = 2'd2,
    CTM_MODE_NONE = 2'd3
  } ctm_mode_e;

  typedef enum logic {
    CTM_ST_NORMAL   = 1'b0,
    CTM_ST_OVERFLOW = 1'b1
  } ctm_state_e;

  typedef struct packed {
    logic                  kind;
    logic [CTM_ADDR_W-1:0] pc;
    logic [CTM_ADDR_W-1:0] npc;
    logic [3:0]            flags;
    logic [CTM_TIME_W-1:0] timestamp;
    logic [15:0]           drop_cnt;
  } ctm_trace_event_t;

  function automatic logic [15:0] ctm_drop_sat_add(input logic [15:0] cnt, input logic [2:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {14'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/ctm_trace_frontend_if.sv
// Trace event output stream: valid/ready handshake plus buffer fill level.
interface ctm_trace_frontend_if #(
  parameter int FIFO_DEPTH = 8
);
  import opensocdebug::*;

  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  logic             out_valid;
  logic             out_ready;
  ctm_trace_event_t out_event;
  logic [FILL_W-1:0] fill_level;

  modport master (output out_valid, output out_event, output fill_level, input out_ready);
  modport slave  (input out_valid, input out_event, input fill_level, output out_ready);

endinterface

// File: rtl/ctm_trace_mwfifo.sv
// Multi-write, single-read event buffer; writes land contiguously from port 0,
// read side is first-word-fall-through.
module ctm_trace_mwfifo
  import opensocdebug::*;
#(
  parameter int NUM_WR = 3,
  parameter int DEPTH  = 8,
  localparam int WC_W  = $clog2(NUM_WR + 1),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WC_W-1:0]             wr_cnt,
  input  ctm_trace_event_t [NUM_WR-1:0] wr_data,
  input  logic                        rd_en,
  output ctm_trace_event_t            rd_data,
  output logic                        rd_valid,
  output logic [CNT_W-1:0]            count
);

  localparam int PTR_W = $clog2(DEPTH);

  ctm_trace_event_t   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               valid_r;
  logic               pop_s;
  logic [CNT_W-1:0]   count_s;

  assign pop_s   = rd_en & valid_r;
  assign count_s = count_r + CNT_W'(wr_cnt) - CNT_W'(pop_s);

  // Storage, pointers and occupancy; the writer never exceeds free space.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (WC_W'(k) < wr_cnt) begin
          mem_r[wr_ptr_r + PTR_W'(k)] <= wr_data[k];
        end
      end
      wr_ptr_r <= wr_ptr_r + PTR_W'(wr_cnt);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
      count_r  <= count_s;
      valid_r  <= (count_s != '0);
    end
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = valid_r;
  assign count    = count_r;

endmodule

// File: rtl/ctm_trace_frontend.sv
// Retire-lane trace capture: filtering, overflow state machine, timestamp and
// drop counting in front of a multi-write event buffer.
module ctm_trace_frontend
  import opensocdebug::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIME_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_enable,
  input  logic [1:0]                           cfg_mode,
  input  logic [NUM_LANES-1:0]                 lane_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_pc,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_npc,
  input  logic [NUM_LANES-1:0]                 lane_jal,
  input  logic [NUM_LANES-1:0]                 lane_jalr,
  input  logic [NUM_LANES-1:0]                 lane_br_taken,
  input  logic [NUM_LANES-1:0]                 lane_xcpt,
  ctm_trace_frontend_if.master                 trace
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int NUM_WR = NUM_LANES + 1;
  localparam int WC_W   = $clog2(NUM_WR + 1);
  localparam int DC_W   = 3;

  ctm_state_e                    state_r, state_s;
  logic [TIME_WIDTH-1:0]         time_r;
  logic [15:0]                   drop_cnt_r, drop_cnt_s;
  logic [NUM_LANES-1:0]          pass_s, qualify_s;
  logic [CNT_W-1:0]              count_s, free_s;
  logic                          marker_s;
  logic [WC_W-1:0]               wr_cnt_s;
  logic [DC_W-1:0]               drop_s;
  ctm_trace_event_t [NUM_WR-1:0] slot_s;

  assign free_s = CNT_W'(FIFO_DEPTH) - count_s;

  // Per-lane filter against the selected mode.
  always_comb begin
    pass_s    = '0;
    qualify_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (cfg_mode)
        CTM_MODE_ALL:  pass_s[i] = 1'b1;
        CTM_MODE_CTRL: pass_s[i] = lane_jal[i] | lane_jalr[i] | lane_br_taken[i] | lane_xcpt[i];
        CTM_MODE_XCPT: pass_s[i] = lane_xcpt[i];
        CTM_MODE_NONE: pass_s[i] = 1'b0;
        default:       pass_s[i] = 1'b0;
      endcase
      qualify_s[i] = lane_valid[i] & cfg_enable & pass_s[i];
    end
  end

  // Pack marker then qualifying lanes into contiguous write slots; count the rest as drops.
  always_comb begin
    ctm_trace_event_t ev_s;
    ev_s     = '0;
    slot_s   = '0;
    wr_cnt_s = '0;
    drop_s   = '0;
    marker_s = cfg_enable && (state_r == CTM_ST_OVERFLOW) && (free_s >= CNT_W'(NUM_WR));
    if (marker_s) begin
      ev_s.kind      = CTM_KIND_OVERFLOW;
      ev_s.timestamp = CTM_TIME_W'(time_r);
      ev_s.drop_cnt  = drop_cnt_r;
      slot_s[0]      = ev_s;
      wr_cnt_s       = WC_W'(1);
    end else begin
      wr_cnt_s = '0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (qualify_s[i]) begin
        if (((state_r == CTM_ST_NORMAL) || marker_s) && (CNT_W'(wr_cnt_s) < free_s)) begin
          ev_s                      = '0;
          ev_s.kind                 = CTM_KIND_INSTR;
          ev_s.pc                   = CTM_ADDR_W'(lane_pc[i]);
          ev_s.npc                  = CTM_ADDR_W'(lane_npc[i]);
          ev_s.flags[CTM_FLAG_JAL]  = lane_jal[i];
          ev_s.flags[CTM_FLAG_JALR] = lane_jalr[i];
          ev_s.flags[CTM_FLAG_BR]   = lane_br_taken[i];
          ev_s.flags[CTM_FLAG_XCPT] = lane_xcpt[i];
          ev_s.timestamp            = CTM_TIME_W'(time_r);
          slot_s[wr_cnt_s]          = ev_s;
          wr_cnt_s                  = wr_cnt_s + WC_W'(1);
        end else begin
          drop_s = drop_s + DC_W'(1);
        end
      end else begin
        drop_s = drop_s;
      end
    end
  end

  // Overflow state machine and saturating drop counter.
  always_comb begin
    state_s    = state_r;
    drop_cnt_s = drop_cnt_r;
    case (state_r)
      CTM_ST_NORMAL: begin
        if (drop_s != '0) state_s = CTM_ST_OVERFLOW;
        else              state_s = CTM_ST_NORMAL;
      end
      CTM_ST_OVERFLOW: begin
        if (marker_s) state_s = CTM_ST_NORMAL;
        else          state_s = CTM_ST_OVERFLOW;
      end
      default: state_s = CTM_ST_NORMAL;
    endcase
    if (marker_s) begin
      drop_cnt_s = '0;
    end else if (drop_s != '0) begin
      drop_cnt_s = ctm_drop_sat_add(drop_cnt_r, drop_s);
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
  end

  // State, free-running time base and drop counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= CTM_ST_NORMAL;
      time_r     <= '0;
      drop_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      time_r     <= time_r + TIME_WIDTH'(1);
      drop_cnt_r <= drop_cnt_s;
    end
  end

  ctm_trace_mwfifo #(
    .NUM_WR (NUM_WR),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_cnt   (wr_cnt_s),
    .wr_data  (slot_s),
    .rd_en    (trace.out_ready),
    .rd_data  (trace.out_event),
    .rd_valid (trace.out_valid),
    .count    (count_s)
  );

  assign trace.fill_level = count_s;

endmodule

// File: tb/tb_ctm_trace_frontend.sv
// Directed bench for ctm_trace_frontend: filtering, ordering, overflow markers,
// drop-count saturation, mid-run reset and time-counter wrap.
module tb_ctm_trace_frontend;
  import opensocdebug::*;

  logic             clk;
  logic             rst;
  logic             cfg_enable;
  logic [1:0]       cfg_mode;
  logic [1:0]       lane_valid;
  logic [1:0][31:0] lane_pc;
  logic [1:0][31:0] lane_npc;
  logic [1:0]       lane_jal;
  logic [1:0]       lane_jalr;
  logic [1:0]       lane_br_taken;
  logic [1:0]       lane_xcpt;

  int               n_checks;
  int               n_fail;
  logic [31:0]      cyc;
  logic [31:0]      ts_c [9];
  logic [31:0]      t0;
  ctm_trace_event_t got_q [$];

  ctm_trace_frontend_if #(.FIFO_DEPTH(8)) trace ();

  ctm_trace_frontend #(
    .NUM_LANES  (2),
    .ADDR_WIDTH (32),
    .FIFO_DEPTH (8),
    .TIME_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_enable    (cfg_enable),
    .cfg_mode      (cfg_mode),
    .lane_valid    (lane_valid),
    .lane_pc       (lane_pc),
    .lane_npc      (lane_npc),
    .lane_jal      (lane_jal),
    .lane_jalr     (lane_jalr),
    .lane_br_taken (lane_br_taken),
    .lane_xcpt     (lane_xcpt),
    .trace         (trace)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time base: value a lane accepted at the next rising edge carries.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 32'd0;
    else      cyc <= cyc + 32'd1;
  end

  // Capture every handshake, sampled between edges.
  always begin
    @(negedge clk);
    #2;
    if (rst && trace.out_valid && trace.out_ready) got_q.push_back(trace.out_event);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_lane(input int i, input logic [31:0] pc, input logic [3:0] fl);
    lane_valid[i]    = 1'b1;
    lane_pc[i]       = pc;
    lane_npc[i]      = pc + 32'h10;
    lane_jal[i]      = fl[0];
    lane_jalr[i]     = fl[1];
    lane_br_taken[i] = fl[2];
    lane_xcpt[i]     = fl[3];
  endtask

  task automatic idle_lanes();
    lane_valid    = 2'b00;
    lane_pc       = '0;
    lane_npc      = '0;
    lane_jal      = 2'b00;
    lane_jalr     = 2'b00;
    lane_br_taken = 2'b00;
    lane_xcpt     = 2'b00;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (trace.fill_level != 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk_eq(tag, 64'(trace.fill_level), 64'd0);
  endtask

  task automatic expect_ev(input string tag, input logic kind, input logic [31:0] pc,
                           input logic [3:0] fl, input logic [31:0] ts, input logic [15:0] drop);
    ctm_trace_event_t e;
    if (got_q.size() == 0) begin
      chk_eq({tag, "_present"}, 64'd0, 64'd1);
      return;
    end
    e = got_q.pop_front();
    chk_eq({tag, "_kind"},  64'(e.kind),      64'(kind));
    chk_eq({tag, "_pc"},    64'(e.pc),        64'(pc));
    chk_eq({tag, "_npc"},   64'(e.npc),       kind ? 64'd0 : 64'(pc + 32'h10));
    chk_eq({tag, "_flags"}, 64'(e.flags),     64'(fl));
    chk_eq({tag, "_time"},  64'(e.timestamp), 64'(ts));
    chk_eq({tag, "_drop"},  64'(e.drop_cnt),  64'(drop));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    cfg_enable = 1'b0;
    cfg_mode   = 2'd0;
    trace.out_ready = 1'b1;
    idle_lanes();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_eq("rst_valid", 64'(trace.out_valid), 64'd0);
    chk_eq("rst_fill",  64'(trace.fill_level), 64'd0);

    // Both lanes in the first cycle after release, mode 0
    rst        = 1'b1;
    cfg_enable = 1'b1;
    drive_lane(0, 32'h1000, 4'b0000);
    drive_lane(1, 32'h2000, 4'b0000);
    @(negedge clk);
    idle_lanes();
    wait_empty("m0_drain");
    expect_ev("m0_l0", CTM_KIND_INSTR, 32'h1000, 4'b0000, 32'd0, 16'd0);
    expect_ev("m0_l1", CTM_KIND_INSTR, 32'h2000, 4'b0000, 32'd0, 16'd0);
    chk_eq("m0_count", 64'(got_q.size()), 64'd0);

    // Mode 1: plain lane filtered, jal lane kept
    cfg_mode = 2'd1;
    t0 = cyc;
    drive_lane(0, 32'h3000, 4'b0000);
    drive_lane(1, 32'h3100, 4'b0001);
    @(negedge clk);
    idle_lanes();
    wait_empty("m1_drain");
    expect_ev("m1_l1", CTM_KIND_INSTR, 32'h3100, 4'b0001, t0, 16'd0);
    chk_eq("m1_count", 64'(got_q.size()), 64'd0);

    // Mode 2: only the exception lane
    cfg_mode = 2'd2;
    t0 = cyc;
    drive_lane(0, 32'h4000, 4'b1000);
    drive_lane(1, 32'h4100, 4'b0100);
    @(negedge clk);
    idle_lanes();
    wait_empty("m2_drain");
    expect_ev("m2_l0", CTM_KIND_INSTR, 32'h4000, 4'b1000, t0, 16'd0);
    chk_eq("m2_count", 64'(got_q.size()), 64'd0);

    // Mode 3 and disabled capture: nothing written or counted
    cfg_mode = 2'd3;
    drive_lane(0, 32'h4200, 4'b0001);
    drive_lane(1, 32'h4300, 4'b1000);
    @(negedge clk);
    cfg_mode   = 2'd0;
    cfg_enable = 1'b0;
    @(negedge clk);
    idle_lanes();
    cfg_enable = 1'b1;
    wait_empty("m3_drain");
    chk_eq("m3_count", 64'(got_q.size()), 64'd0);
    chk_eq("m3_drops", 64'(dut.drop_cnt_r), 64'd0);

    // Overflow: fill with ready low, then release with lanes still active
    trace.out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) begin
        chk_eq("ovf_fill",  64'(trace.fill_level), 64'd8);
        chk_eq("ovf_state", 64'(dut.state_r), 64'(CTM_ST_OVERFLOW));
        chk_eq("ovf_drops", 64'(dut.drop_cnt_r), 64'd2);
      end
      trace.out_ready = (c >= 5);
      ts_c[c] = cyc;
      drive_lane(0, 32'h5000 + 32'(c) * 32'h20, 4'b0000);
      drive_lane(1, 32'h5008 + 32'(c) * 32'h20, 4'b0000);
      @(negedge clk);
    end
    idle_lanes();
    wait_empty("ovf_drain");
    for (int c = 0; c < 4; c++) begin
      expect_ev($sformatf("ovf_c%0d_l0", c), CTM_KIND_INSTR, 32'h5000 + 32'(c) * 32'h20, 4'b0000, ts_c[c], 16'd0);
      expect_ev($sformatf("ovf_c%0d_l1", c), CTM_KIND_INSTR, 32'h5008 + 32'(c) * 32'h20, 4'b0000, ts_c[c], 16'd0);
    end
    expect_ev("ovf_marker", CTM_KIND_OVERFLOW, 32'h0, 4'b0000, ts_c[8], 16'd8);
    expect_ev("ovf_c8_l0", CTM_KIND_INSTR, 32'h5100, 4'b0000, ts_c[8], 16'd0);
    expect_ev("ovf_c8_l1", CTM_KIND_INSTR, 32'h5108, 4'b0000, ts_c[8], 16'd0);
    chk_eq("ovf_count", 64'(got_q.size()), 64'd0);
    chk_eq("ovf_state_back", 64'(dut.state_r), 64'(CTM_ST_NORMAL));

    // Drop counter saturation: more than 65535 drops before the marker
    trace.out_ready = 1'b0;
    t0 = cyc;
    drive_lane(0, 32'hA000, 4'b0000);
    drive_lane(1, 32'hA008, 4'b0000);
    repeat (33000) @(negedge clk);
    idle_lanes();
    trace.out_ready = 1'b1;
    ts_c[0] = cyc;
    wait_empty("sat_drain");
    for (int k = 0; k < 8; k++) begin
      expect_ev($sformatf("sat_ev%0d", k), CTM_KIND_INSTR, (k % 2 == 0) ? 32'hA000 : 32'hA008,
                4'b0000, t0 + 32'(k / 2), 16'd0);
    end
    expect_ev("sat_marker", CTM_KIND_OVERFLOW, 32'h0, 4'b0000, ts_c[0] + 32'd3, 16'hFFFF);
    chk_eq("sat_count", 64'(got_q.size()), 64'd0);

    // Reset with six events buffered
    trace.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_lane(0, 32'hB000 + 32'(c) * 32'h20, 4'b0000);
      drive_lane(1, 32'hB008 + 32'(c) * 32'h20, 4'b0000);
      @(negedge clk);
    end
    idle_lanes();
    chk_eq("mid_fill", 64'(trace.fill_level), 64'd6);
    rst = 1'b0;
    #1;
    chk_eq("mid_rst_valid", 64'(trace.out_valid), 64'd0);
    chk_eq("mid_rst_fill",  64'(trace.fill_level), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    trace.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk_eq("mid_after_count", 64'(got_q.size()), 64'd0);
    chk_eq("mid_after_valid", 64'(trace.out_valid), 64'd0);

    // Time counter wrap
    force dut.time_r = 32'hFFFF_FFFF;
    #1;
    release dut.time_r;
    @(negedge clk);
    drive_lane(0, 32'hC000, 4'b0000);
    drive_lane(1, 32'hC008, 4'b0000);
    @(negedge clk);
    drive_lane(0, 32'hC100, 4'b0000);
    drive_lane(1, 32'hC108, 4'b0000);
    @(negedge clk);
    idle_lanes();
    wait_empty("wrap_drain");
    expect_ev("wrap_a0", CTM_KIND_INSTR, 32'hC000, 4'b0000, 32'd0, 16'd0);
    expect_ev("wrap_a1", CTM_KIND_INSTR, 32'hC008, 4'b0000, 32'd0, 16'd0);
    expect_ev("wrap_b0", CTM_KIND_INSTR, 32'hC100, 4'b0000, 32'd1, 16'd0);
    expect_ev("wrap_b1", CTM_KIND_INSTR, 32'hC108, 4'b0000, 32'd1, 16'd0);
    chk_eq("wrap_count", 64'(got_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctm_trace_frontend.md
CTM_TRACE_FRONTEND -- requirements
Module: ctm_trace_frontend

Interface
REQ-001 Parameter NUM_LANES, default 2, number of retire lanes (1..4).
REQ-002 Parameter ADDR_WIDTH, default 32, PC width.
REQ-003 Parameter FIFO_DEPTH, default 8, event buffer entries (power of two, >= 2*NUM_LANES).
REQ-004 Parameter TIME_WIDTH, default 32, timestamp width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cfg_enable  in  1  capture enable.
REQ-008 cfg_mode  in  2  filter: 0 all retired, 1 control transfer only, 2 exceptions only, 3 none.
REQ-009 lane_valid  in  NUM_LANES  instruction retired on lane i; lane 0 oldest.
REQ-010 lane_pc, lane_npc  in  NUM_LANES x ADDR_WIDTH  PC and next/target PC.
REQ-011 lane_jal, lane_jalr, lane_br_taken, lane_xcpt  in  NUM_LANES each  event-type flags.
REQ-012 out_valid  out  1  event available.
REQ-013 out_ready  in  1  consumer accepts; transfer when out_valid and out_ready.
REQ-014 out_event  out  ctm_trace_event_t  {kind(1: 0=instr, 1=overflow marker), pc, npc, flags[3:0], time, drop_cnt[15:0]}.
REQ-015 fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Free-running time counter increments every cycle and wraps modulo 2^TIME_WIDTH; each event carries the counter value of its acceptance cycle.
REQ-017 Lane i qualifies when lane_valid[i], cfg_enable=1, and mode passes: mode 1 requires jal|jalr|br_taken|xcpt, mode 2 requires xcpt, mode 3 rejects all.
REQ-018 Free slots are FIFO_DEPTH minus occupancy at start of cycle; a same-cycle pop does not add free space.
REQ-019 State NORMAL: qualifying lanes are written in ascending lane order, contiguous, in one cycle, while free slots last; qualifying lanes beyond free space are dropped, added to drop_cnt, and state goes to OVERFLOW.
REQ-020 State OVERFLOW: all qualifying lanes are dropped and counted until free slots >= NUM_LANES+1 at start of cycle.
REQ-021 In that cycle one overflow marker (kind=1, drop_cnt, current time, pc/npc/flags zero) is written first, that cycle's qualifying lanes behind it, drop_cnt clears, state returns to NORMAL.
REQ-022 drop_cnt saturates at 16'hFFFF.
REQ-023 Read side is first-word-fall-through: out_valid=1 whenever occupancy>0; out_event is the oldest entry; one pop per handshake.
REQ-024 Output order equals write order; within a cycle, marker precedes lanes, lanes ascend.
REQ-025 cfg_enable=0: nothing written, nothing counted, FIFO continues to drain; state and drop_cnt held.
REQ-026 Simultaneous push and pop in full FIFO: free slots per REQ-018 (zero), so pushes overflow even if a pop occurs.
REQ-027 Read and write pointers wrap modulo FIFO_DEPTH; full vs empty distinguished by occupancy counter.

Reset
REQ-028 rst low asynchronously: FIFO empty, out_valid=0, fill_level=0, time=0, drop_cnt=0, state NORMAL.
REQ-029 Reset mid-operation discards all buffered events; no marker is emitted for them after release.
REQ-030 First acceptance after rst rises carries time=0 if in the first cycle.

Structure
REQ-031 ctm_trace_event_t, event-kind and flag-bit constants, and mode encodings belong in the shared opensocdebug package.
REQ-032 Multi-write, single-read buffer is sub-module ctm_trace_mwfifo (parameters NUM_LANES+1 write ports, FIFO_DEPTH).
REQ-033 Filter, state machine, time and drop counters reside in the top module.

Verification
REQ-034 Mode 0, NUM_LANES=2, both lanes valid one cycle, out_ready=1 -> two events, lane0 then lane1, identical time.
REQ-035 Mode 1, lane0 plain, lane1 jal -> only lane1 event, flags jal bit set.
REQ-036 FIFO_DEPTH=8, out_ready=0, 5 cycles both lanes valid -> 8 stored, 2 dropped, state OVERFLOW; release out_ready, lanes still active -> marker with drop_cnt equal to all drops until 3 slots free, then lanes resume.
REQ-037 300000 dropped events in OVERFLOW -> marker drop_cnt=16'hFFFF.
REQ-038 rst low with 6 events buffered -> out_valid=0 immediately, fill_level=0, no marker after release.
REQ-039 Time counter preloaded by forcing to 2^32-1 -> next event time 0, order unaffected.
